// File: rtl/dcmi_frame_loader_pkg.sv
// Shared definitions for the DCMI frame loader: parser states, framing constants
// and error codes.
package dcmi_frame_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_H   = 3'd1,
        S_LEN_L   = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_LAUNCH  = 3'd5,
        S_WAIT_HI = 3'd6,
        S_WAIT_LO = 3'd7
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    // Transmitter buffer depth; payloads must stay strictly below it.
    function automatic int max_len(input int len_bits);
        return 1 << len_bits;
    endfunction

endpackage

// File: rtl/dcmi_frame_loader_timeout.sv
// Saturating inactivity counter: clear wins over enable, expired holds at all-ones
// until the next clear.
module byte_timeout #(
    parameter int TIMEOUT_BITS = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_BITS-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = &count;

endmodule

// File: rtl/dcmi_frame_loader.sv
// Host-side framing stage: parses A5/len/payload/checksum packets from the host link,
// writes the payload into the DCMI transmitter buffer and launches the frame.
module dcmi_frame_loader
    import dcmi_frame_loader_pkg::*;
#(
    parameter int LEN_BITS     = 10,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic       Clk,
    input  logic       nRst,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic       RX_READY,
    input  logic       TX_BUSY,
    output logic [7:0] DO,
    output logic       WR,
    output logic       RST,
    output logic       START,
    output logic [7:0] FRAME_CNT,
    output logic       ERR,
    output logic [1:0] ERR_CODE,
    output state_t     state_dbg
);

    localparam int MAX_LEN = max_len(LEN_BITS);

    // Handshake: a byte moves on any rising edge where RX_VALID && RX_READY; RX_READY
    // depends only on the state, never on RX_VALID, and the host may hold RX_VALID.
    state_t      state, base_next, next_state;
    logic        accept;
    logic [7:0]  len_h;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] byte_cnt;
    logic [7:0]  sum;
    logic        len_bad, last_byte, csum_ok;
    logic        timed_out, timeout_hit, to_clear, to_enable;

    logic        wr_d, rst_d, start_d, err_d;
    logic [7:0]  do_d;
    logic [1:0]  err_code_d;

    assign RX_READY  = (state inside {S_IDLE, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CSUM});
    assign accept    = RX_VALID && RX_READY;
    assign state_dbg = state;

    assign len_full  = {len_h, RX_DATA};
    assign len_bad   = (len_full == 16'd0) || (int'(len_full) > MAX_LEN - 1);
    assign last_byte = (byte_cnt == len - 16'd1);
    assign csum_ok   = (sum == RX_DATA);

    assign to_clear  = accept || (next_state != state);
    assign to_enable = (state != S_IDLE);

    byte_timeout #(
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) u_timeout (
        .clk    (Clk),
        .rst_n  (nRst),
        .clear  (to_clear),
        .enable (to_enable),
        .expired(timed_out)
    );

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        base_next = state;
        unique case (state)
            S_IDLE:    if (accept && RX_DATA == SYNC_BYTE) base_next = S_LEN_H;
            S_LEN_H:   if (accept) base_next = S_LEN_L;
            S_LEN_L:   if (accept) base_next = len_bad ? S_IDLE : S_PAYLOAD;
            S_PAYLOAD: if (accept && last_byte) base_next = S_CSUM;
            S_CSUM:    if (accept) base_next = csum_ok ? S_LAUNCH : S_IDLE;
            S_LAUNCH:  base_next = S_WAIT_HI;
            S_WAIT_HI: if (TX_BUSY) base_next = S_WAIT_LO;
            S_WAIT_LO: if (!TX_BUSY) base_next = S_IDLE;
            default:   base_next = S_IDLE;
        endcase
        // Progress always beats a timeout that saturates in the same cycle.
        timeout_hit = timed_out && !accept && (base_next == state);
        next_state  = timeout_hit ? S_IDLE : base_next;
    end

    always_comb begin
        rst_d      = (state == S_IDLE) && (next_state == S_LEN_H);
        wr_d       = (state == S_PAYLOAD) && accept;
        do_d       = wr_d ? RX_DATA : DO;
        start_d    = (next_state == S_LAUNCH);
        err_d      = 1'b0;
        err_code_d = ERR_CODE;
        if (timeout_hit) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end else if (state == S_LEN_L && accept && len_bad) begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_LEN;
        end else if (state == S_CSUM && accept && !csum_ok) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHECKSUM;
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            DO        <= 8'd0;
            WR        <= 1'b0;
            RST       <= 1'b0;
            START     <= 1'b0;
            ERR       <= 1'b0;
            ERR_CODE  <= ERR_NONE;
            FRAME_CNT <= 8'd0;
        end else begin
            DO       <= do_d;
            WR       <= wr_d;
            RST      <= rst_d;
            START    <= start_d;
            ERR      <= err_d;
            ERR_CODE <= err_code_d;
            if (start_d) FRAME_CNT <= FRAME_CNT + 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            len_h    <= 8'd0;
            len      <= 16'd0;
            byte_cnt <= 16'd0;
            sum      <= 8'd0;
        end else begin
            if (state == S_LEN_H && accept) len_h <= RX_DATA;
            if (state == S_LEN_L && accept) begin
                len      <= len_full;
                byte_cnt <= 16'd0;
                sum      <= 8'd0;
            end
            if (wr_d) begin
                byte_cnt <= byte_cnt + 16'd1;
                sum      <= sum + RX_DATA;
            end
        end
    end

endmodule

// File: tb/tb_dcmi_frame_loader.sv
// Directed bench for dcmi_frame_loader: good/bad frames, length limits, resync,
// timeouts and mid-packet reset, with a write-data scoreboard.
module tb_dcmi_frame_loader;
    import dcmi_frame_loader_pkg::*;

    logic       Clk = 1'b0;
    logic       nRst = 1'b0;
    logic [7:0] RX_DATA = 8'd0;
    logic       RX_VALID = 1'b0;
    logic       RX_READY;
    logic       TX_BUSY = 1'b0;
    logic [7:0] DO;
    logic       WR, RST, START, ERR;
    logic [7:0] FRAME_CNT;
    logic [1:0] ERR_CODE;
    state_t     state_dbg;

    int n_checks = 0;
    int n_fail = 0;
    int rst_seen = 0, wr_seen = 0, start_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pl[0:1023];
    logic [7:0] exp_frames = 8'd0;

    dcmi_frame_loader #(
        .LEN_BITS(10),
        .TIMEOUT_BITS(4)
    ) dut (
        .Clk(Clk), .nRst(nRst), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .TX_BUSY(TX_BUSY), .DO(DO), .WR(WR), .RST(RST),
        .START(START), .FRAME_CNT(FRAME_CNT), .ERR(ERR), .ERR_CODE(ERR_CODE),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard / monitor
    always @(negedge Clk) begin
        if (nRst) begin
            if (WR) begin
                wr_seen++;
                if (exp_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
                else check("do", {24'd0, DO}, {24'd0, exp_q.pop_front()});
            end
            if (RST) rst_seen++;
            if (START) start_seen++;
            if (WR || RST || START)
                check("excl", int'(WR) + int'(RST) + int'(START), 32'd1);
            if (state_dbg == S_WAIT_HI || state_dbg == S_WAIT_LO)
                check("wait_quiet", {30'd0, WR, RST}, 32'd0);
        end
    end

    // driver tasks; called in the negedge phase
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (!RX_READY && guard < 100) begin
            @(negedge Clk);
            guard++;
        end
        if (guard >= 100) check("ready_bound", 32'd0, 32'd1);
        @(negedge Clk);
        RX_VALID = 1'b0;
    endtask

    function automatic logic [7:0] calc_sum(input int n);
        logic [7:0] s = 8'd0;
        for (int i = 0; i < n; i++) s = s + pl[i];
        return s;
    endfunction

    task automatic send_frame(input int n, input logic [7:0] csum);
        logic [15:0] l = 16'(n);
        send_byte(SYNC_BYTE);
        send_byte(l[15:8]);
        send_byte(l[7:0]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pl[i]);
            send_byte(pl[i]);
        end
        send_byte(csum);
    endtask

    task automatic tx_handshake;
        @(negedge Clk);
        check("ready_wait_hi", {31'd0, RX_READY}, 32'd0);
        TX_BUSY = 1'b1;
        repeat (3) @(negedge Clk);
        check("ready_wait_lo", {31'd0, RX_READY}, 32'd0);
        check("state_wait_lo", {29'd0, state_dbg}, {29'd0, S_WAIT_LO});
        TX_BUSY = 1'b0;
        @(negedge Clk);
        check("ready_after_tx", {31'd0, RX_READY}, 32'd1);
    endtask

    task automatic expect_launch(input string tag);
        exp_frames = exp_frames + 8'd1;
        check({tag, "_start"}, {31'd0, START}, 32'd1);
        check({tag, "_frame_cnt"}, {24'd0, FRAME_CNT}, {24'd0, exp_frames});
        check({tag, "_ready_low"}, {31'd0, RX_READY}, 32'd0);
    endtask

    task automatic wait_err(input int limit, output int cyc);
        cyc = 0;
        while (!ERR && cyc < limit) begin
            @(negedge Clk);
            cyc++;
        end
        if (cyc >= limit) check("err_bound", 32'd0, 32'd1);
    endtask

    initial begin
        int base_rst, base_wr, base_start, cyc;

        repeat (3) @(negedge Clk);
        check("rst_do", {24'd0, DO}, 32'd0);
        check("rst_outs", {28'd0, WR, RST, START, ERR}, 32'd0);
        check("rst_err_code", {30'd0, ERR_CODE}, 32'd0);
        check("rst_frame_cnt", {24'd0, FRAME_CNT}, 32'd0);
        check("rst_ready", {31'd0, RX_READY}, 32'd1);
        check("rst_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        nRst = 1'b1;
        @(negedge Clk);

        // basic frame A5 00 03 11 22 33 66
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        base_rst = rst_seen; base_wr = wr_seen; base_start = start_seen;
        send_frame(3, 8'h66);
        expect_launch("basic");
        tx_handshake();
        check("basic_rst_cnt", rst_seen - base_rst, 32'd1);
        check("basic_wr_cnt", wr_seen - base_wr, 32'd3);
        check("basic_start_cnt", start_seen - base_start, 32'd1);
        check("basic_no_err", {31'd0, ERR}, 32'd0);

        // checksum error, then recovery
        base_start = start_seen;
        send_frame(3, 8'h67);
        check("csum_err", {31'd0, ERR}, 32'd1);
        check("csum_code", {30'd0, ERR_CODE}, {30'd0, ERR_CHECKSUM});
        check("csum_no_start", {31'd0, START}, 32'd0);
        check("csum_frame_cnt", {24'd0, FRAME_CNT}, {24'd0, exp_frames});
        @(negedge Clk);
        check("csum_err_pulse", {31'd0, ERR}, 32'd0);
        check("csum_code_held", {30'd0, ERR_CODE}, {30'd0, ERR_CHECKSUM});
        check("csum_start_cnt", start_seen - base_start, 32'd0);
        pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'hF0;
        send_frame(3, 8'hF3);
        expect_launch("recover");
        tx_handshake();

        // length limits
        send_byte(SYNC_BYTE); send_byte(8'h00); send_byte(8'h00);
        check("len0_err", {31'd0, ERR}, 32'd1);
        check("len0_code", {30'd0, ERR_CODE}, {30'd0, ERR_BAD_LEN});
        check("len0_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        send_byte(SYNC_BYTE); send_byte(8'h04); send_byte(8'h00);
        check("len1024_err", {31'd0, ERR}, 32'd1);
        check("len1024_code", {30'd0, ERR_CODE}, {30'd0, ERR_BAD_LEN});
        check("len1024_state", {29'd0, state_dbg}, {29'd0, S_IDLE});

        for (int i = 0; i < 1023; i++) pl[i] = 8'(i * 7 + 3);
        base_wr = wr_seen;
        send_frame(1023, calc_sum(1023));
        expect_launch("max_len");
        tx_handshake();
        check("max_len_wr_cnt", wr_seen - base_wr, 32'd1023);

        // garbage before sync, A5 inside payload: sum A5+01+A5+02 = 4D
        base_rst = rst_seen;
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        pl[0] = 8'hA5; pl[1] = 8'h01; pl[2] = 8'hA5; pl[3] = 8'h02;
        send_frame(4, 8'h4D);
        expect_launch("resync");
        tx_handshake();
        check("resync_rst_cnt", rst_seen - base_rst, 32'd1);

        // host stalls after two payload bytes
        send_byte(SYNC_BYTE); send_byte(8'h00); send_byte(8'h05);
        exp_q.push_back(8'h11); send_byte(8'h11);
        exp_q.push_back(8'h22); send_byte(8'h22);
        wait_err(40, cyc);
        check("stall_delay_window", {31'd0, (cyc >= 15 && cyc <= 17)}, 32'd1);
        check("stall_code", {30'd0, ERR_CODE}, {30'd0, ERR_TIMEOUT});
        check("stall_state", {29'd0, state_dbg}, {29'd0, S_IDLE});
        check("stall_ready", {31'd0, RX_READY}, 32'd1);

        // transmitter never raises TX_BUSY
        pl[0] = 8'h40; pl[1] = 8'h41;
        send_frame(2, 8'h81);
        expect_launch("txlow");
        wait_err(40, cyc);
        check("txlow_code", {30'd0, ERR_CODE}, {30'd0, ERR_TIMEOUT});
        check("txlow_state", {29'd0, state_dbg}, {29'd0, S_IDLE});

        // reset right after the LEN_L byte
        base_start = start_seen;
        send_byte(SYNC_BYTE); send_byte(8'h00); send_byte(8'h02);
        nRst = 1'b0;
        #1;
        check("mid_rst_do", {24'd0, DO}, 32'd0);
        check("mid_rst_outs", {28'd0, WR, RST, START, ERR}, 32'd0);
        check("mid_rst_err_code", {30'd0, ERR_CODE}, 32'd0);
        check("mid_rst_frame_cnt", {24'd0, FRAME_CNT}, 32'd0);
        check("mid_rst_ready", {31'd0, RX_READY}, 32'd1);
        exp_frames = 8'd0;
        @(negedge Clk);
        nRst = 1'b1;
        @(negedge Clk);
        check("mid_rst_no_start", start_seen - base_start, 32'd0);
        pl[0] = 8'h10; pl[1] = 8'h20;
        send_frame(2, 8'h30);
        expect_launch("after_rst");
        tx_handshake();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dcmi_frame_loader.md
# dcmi_frame_loader

Host-side framing stage that feeds the DCMI transmitter. It accepts a byte stream from the host link receiver over a valid/ready handshake and parses packets of the form sync, length, payload, checksum. It loads the payload into the transmitter buffer and issues the frame-start trigger only after the checksum matches. It then blocks new input until the transmitter has finished sending.

## Interface
Parameters:
- LEN_BITS, 10, transmitter buffer address width; MAX_LEN = 2^LEN_BITS.
- TIMEOUT_BITS, 16, width of the inter-byte / transmit-wait timeout counter.

Ports:
- Clk  in  1  the single clock; all logic on rising edge.
- nRst  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  host byte.
- RX_VALID  in  1  RX_DATA valid.
- RX_READY  out  1  loader can accept a byte; a byte transfers on RX_VALID && RX_READY.
- TX_BUSY  in  1  transmitter frame active (its DSYNC).
- DO  out  8  byte to transmitter buffer.
- WR  out  1  buffer write strobe, one cycle per byte.
- RST  out  1  buffer write-pointer reset pulse.
- START  out  1  frame-start pulse.
- FRAME_CNT  out  8  frames launched, wraps 255→0.
- ERR  out  1  one-cycle error pulse.
- ERR_CODE  out  2  last error: 0 none, 1 bad length, 2 checksum, 3 timeout; held until the next error.

## Operation
- Packet format: 0xA5, LEN_H, LEN_L, N payload bytes, CSUM. N = {LEN_H, LEN_L} is 16-bit. CSUM = 8-bit sum mod 256 of the payload bytes only.
- States: IDLE, LEN_H, LEN_L, PAYLOAD, CSUM, LAUNCH, WAIT_HI, WAIT_LO.
- IDLE: discard non-0xA5 bytes. When 0xA5 is accepted, pulse RST and go to LEN_H.
- LEN_H → LEN_L: store the high byte.
- LEN_L: store the low byte.
  - N == 0 or N > MAX_LEN−1: ERR, code 1, go to IDLE.
  - Otherwise clear the sum and byte counter, then go to PAYLOAD.
- PAYLOAD: each accepted byte drives DO = byte, pulses WR, adds to the sum and increments the counter. After byte N, go to CSUM.
- CSUM:
  - Match: go to LAUNCH.
  - Mismatch: ERR, code 2, go to IDLE, no START. Buffer contents are left stale; the next packet's RST overwrites them.
- LAUNCH: pulse START for one cycle, increment FRAME_CNT, go to WAIT_HI.
- WAIT_HI: wait for TX_BUSY = 1, then go to WAIT_LO.
- WAIT_LO: wait for TX_BUSY = 0, then go to IDLE.
- RX_READY = 1 in IDLE, LEN_H, LEN_L, PAYLOAD and CSUM; 0 in LAUNCH, WAIT_HI and WAIT_LO.
- Timeout: a counter is cleared on every accepted byte and on every state change. It counts in every state except IDLE.
  - Saturation at 2^TIMEOUT_BITS−1 gives ERR, code 3, and a return to IDLE. This covers a stalled host mid-packet and a transmitter that never asserts or never drops TX_BUSY.
- WR, RST and START are mutually exclusive in any cycle. No WR or RST is issued while the state is WAIT_HI or WAIT_LO.
- 0xA5 inside the length, payload or checksum fields is data and causes no resync.

## Timing
- Reset (nRst low, asynchronous):
  - State is IDLE.
  - DO = 0, WR = 0, RST = 0, START = 0, ERR = 0, ERR_CODE = 0, FRAME_CNT = 0.
  - Timeout counter, sum and byte counter are cleared.
  - RX_READY = 1, since it follows the IDLE state.
- RX_READY is decoded combinationally from the state. All other outputs are registered.
- Output latency after the accepting edge:
  - RST, WR and DO are valid in the cycle after the edge that accepts the byte.
  - ERR is asserted in the cycle after the offending byte, or after timeout saturation.
  - START is asserted in the cycle after the CSUM byte is accepted: LAUNCH lasts one cycle.
- Throughput: one byte per cycle with RX_VALID held high. A packet of N bytes is accepted in N+4 cycles.
- Reset asserted mid-packet: the partial packet is dropped and no START is issued. The transmitter buffer is not touched, and the next packet's RST re-arms it.
- TX_BUSY already high in LAUNCH does not matter: WAIT_HI checks TX_BUSY from the cycle after START.

## Structure
- Shared package: state encoding, SYNC_BYTE = 8'hA5, ERR_CODE constants, MAX_LEN derivation.
- Sub-module: byte_timeout, a saturating TIMEOUT_BITS counter with clear and enable inputs and an expired output.
- Parser FSM and datapath (sum, byte counter, length registers) stay in dcmi_frame_loader.

## Test plan
- Frame A5 00 03 11 22 33 66 at one byte per cycle:
  - RST once, then WR ×3 with DO = 11, 22, 33, then START once.
  - FRAME_CNT = 1, RX_READY = 0 until TX_BUSY pulses high then low.
- Same frame with CSUM = 67 → ERR with ERR_CODE = 2, no START, FRAME_CNT unchanged. A following valid frame launches normally.
- Length 00 00 → ERR code 1. Length 04 00 with LEN_BITS = 10 → ERR code 1. Length 03 FF is accepted: 1023 WR pulses, then START.
- Garbage 00 FF 5A before A5, and 0xA5 inside the payload → garbage is ignored and the frame is parsed correctly.
- TIMEOUT_BITS = 4:
  - Host stalls after 2 payload bytes → ERR code 3 after 15 idle cycles, back in IDLE with RX_READY = 1.
  - TX_BUSY held low after START → ERR code 3.
- nRst pulsed low after the LEN_L byte → all outputs at their reset values, no START. A subsequent full frame is sent correctly.
